// File: rtl/ifft8_serial_if.sv
// Streaming bundle for ifft8_serial: bin input channel and sample output channel.
// The upstream/downstream environment uses master, the transform uses slave.
interface ifft8_serial_if #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2*IN_W-1:0]    in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*OUT_W-1:0]   out_data;
  logic                 out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/ifft8_serial.sv
// Serial inverse 8-point DFT: buffers one frame of bins, runs 64 MACs through one
// registered complex multiplier, then streams out the 8 scaled, saturated samples.
module ifft8_serial #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 16,
  parameter int SCALE = 3
) (
  input logic           clk,
  input logic           rst,
  ifft8_serial_if.slave bus
);
  localparam int TW_W   = 16;
  localparam int PROD_W = IN_W + TW_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam int ACC_W  = PROD_W + 3;
  localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(1) << (13 + SCALE);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

  typedef enum logic [1:0] {LOAD, CALC, DRAIN} state_t;

  state_t state, next_state;

  logic [2:0]              bin_idx;
  logic [2:0]              out_idx;
  logic [6:0]              calc_cnt;
  logic [2*IN_W-1:0]       xbuf [8];
  logic [2*OUT_W-1:0]      ybuf [8];
  logic signed [ACC_W-1:0] acc_re, acc_im;
  logic signed [SUM_W-1:0] p_re, p_im;

  logic in_fire, out_fire, calc_done, mac_active;
  logic in_ready_c, out_valid_c, out_last_c;
  logic [2*OUT_W-1:0] out_data_c;

  assign in_fire    = (state == LOAD) && bus.in_valid;
  assign out_fire   = (state == DRAIN) && bus.out_ready;
  assign calc_done  = (state == CALC) && (calc_cnt == 7'd64);
  assign mac_active = (state == CALC) && (calc_cnt != 7'd0);

  // Multiply stage: calc_cnt = {n, k} selects the bin and the twiddle (n*k) mod 8
  logic [2:0] mul_k, mul_n, tw_idx;
  logic signed [TW_W-1:0]   tw_cos, tw_sin;
  logic signed [IN_W-1:0]   x_re, x_im;
  logic signed [PROD_W-1:0] m_rc, m_is, m_rs, m_ic;
  logic signed [SUM_W-1:0]  p_re_next, p_im_next;

  assign mul_k  = calc_cnt[2:0];
  assign mul_n  = calc_cnt[5:3];
  assign tw_idx = mul_n * mul_k;
  assign x_re   = xbuf[mul_k][IN_W-1:0];
  assign x_im   = xbuf[mul_k][2*IN_W-1:IN_W];

  always_comb begin
    tw_cos = 16'sh4000;
    tw_sin = 16'sh0000;
    unique case (tw_idx)
      3'd0: begin tw_cos = 16'sh4000; tw_sin = 16'sh0000; end
      3'd1: begin tw_cos = 16'sh2D41; tw_sin = 16'sh2D41; end
      3'd2: begin tw_cos = 16'sh0000; tw_sin = 16'sh4000; end
      3'd3: begin tw_cos = 16'shD2BF; tw_sin = 16'sh2D41; end
      3'd4: begin tw_cos = 16'shC000; tw_sin = 16'sh0000; end
      3'd5: begin tw_cos = 16'shD2BF; tw_sin = 16'shD2BF; end
      3'd6: begin tw_cos = 16'sh0000; tw_sin = 16'shC000; end
      3'd7: begin tw_cos = 16'sh2D41; tw_sin = 16'shD2BF; end
      default: begin tw_cos = 16'sh4000; tw_sin = 16'sh0000; end
    endcase
  end

  assign m_rc      = PROD_W'(x_re) * PROD_W'(tw_cos);
  assign m_is      = PROD_W'(x_im) * PROD_W'(tw_sin);
  assign m_rs      = PROD_W'(x_re) * PROD_W'(tw_sin);
  assign m_ic      = PROD_W'(x_im) * PROD_W'(tw_cos);
  assign p_re_next = SUM_W'(m_rc) - SUM_W'(m_is);
  assign p_im_next = SUM_W'(m_rs) + SUM_W'(m_ic);

  // Accumulate stage lags the multiplier by one cycle, so it works on index calc_cnt-1
  logic [5:0] acc_idx;
  logic [2:0] acc_k, acc_n;
  logic signed [ACC_W-1:0] acc_sum_re, acc_sum_im, rnd_re, rnd_im;

  assign acc_idx    = 6'(calc_cnt - 7'd1);
  assign acc_k      = acc_idx[2:0];
  assign acc_n      = acc_idx[5:3];
  assign acc_sum_re = ((acc_k == 3'd0) ? '0 : acc_re) + ACC_W'(p_re);
  assign acc_sum_im = ((acc_k == 3'd0) ? '0 : acc_im) + ACC_W'(p_im);
  assign rnd_re     = (acc_sum_re + RND_BIAS) >>> (14 + SCALE);
  assign rnd_im     = (acc_sum_im + RND_BIAS) >>> (14 + SCALE);

  function automatic logic [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
    logic [OUT_W-1:0] r;
    r = v[OUT_W-1:0];
    if (v > SAT_MAX) r = SAT_MAX[OUT_W-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[OUT_W-1:0];
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    out_last_c  = 1'b0;
    out_data_c  = '0;
    unique case (state)
      LOAD: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && bin_idx == 3'd7) next_state = CALC;
      end
      CALC: begin
        if (calc_cnt == 7'd64) next_state = DRAIN;
      end
      DRAIN: begin
        out_valid_c = 1'b1;
        out_data_c  = ybuf[out_idx];
        out_last_c  = (out_idx == 3'd7);
        if (bus.out_ready && out_idx == 3'd7) next_state = LOAD;
      end
      default: next_state = LOAD;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_c;
  assign bus.out_last  = out_last_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_idx  <= '0;
      out_idx  <= '0;
      calc_cnt <= '0;
      acc_re   <= '0;
      acc_im   <= '0;
      p_re     <= '0;
      p_im     <= '0;
    end else begin
      if (in_fire) bin_idx <= bin_idx + 3'd1;
      if (state == CALC) begin
        calc_cnt <= calc_done ? 7'd0 : calc_cnt + 7'd1;
        p_re     <= p_re_next;
        p_im     <= p_im_next;
      end
      if (mac_active) begin
        acc_re <= acc_sum_re;
        acc_im <= acc_sum_im;
      end
      if (out_fire) out_idx <= out_idx + 3'd1;
    end
  end

  // Frame buffers need no reset: every entry is rewritten before it is read
  always_ff @(posedge clk) begin
    if (in_fire) xbuf[bin_idx] <= bus.in_data;
    if (mac_active && acc_k == 3'd7) ybuf[acc_n] <= {sat_out(rnd_im), sat_out(rnd_re)};
  end
endmodule

// File: tb/tb_ifft8_serial.sv
// Self-checking bench for ifft8_serial: directed frames plus random frames,
// compared against a direct inverse-DFT reference computed with integer math.
module tb_ifft8_serial;
  localparam int IN_W  = 19;
  localparam int OUT_W = 16;
  localparam int SCALE = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifft8_serial_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus();

  ifft8_serial #(.IN_W(IN_W), .OUT_W(OUT_W), .SCALE(SCALE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checkCount = 0;
  int failCount  = 0;
  int cycleCnt   = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  int twCos[8];
  int twSin[8];
  logic [2*IN_W-1:0]  frameBuf[8];
  logic [2*IN_W-1:0]  inQ[$];
  logic [2*OUT_W-1:0] expQ[$];
  int firstEdges[$];
  int lastEdges[$];
  int lastOutEdges[$];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at cycle %0d", tag, actual, expected, cycleCnt);
    end
  endtask

  task automatic clearQueues();
    inQ.delete();
    expQ.delete();
    firstEdges.delete();
    lastEdges.delete();
    lastOutEdges.delete();
  endtask

  task automatic setImpulse(input int bin, input int re);
    for (int k = 0; k < 8; k++) frameBuf[k] = '0;
    frameBuf[bin] = {{IN_W{1'b0}}, IN_W'(re)};
  endtask

  function automatic longint scaleSat(input longint s);
    longint v;
    v = (s + (longint'(1) << (13 + SCALE))) >>> (14 + SCALE);
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  // y[n] = (1/8) * sum_k X[k] * exp(+j*2*pi*n*k/8), twiddles quantised to Q2.14
  task automatic queueFrame();
    for (int n = 0; n < 8; n++) begin
      longint sr, si, vr, vi;
      sr = 0;
      si = 0;
      for (int k = 0; k < 8; k++) begin
        logic signed [IN_W-1:0] xr, xi;
        int m;
        xr = frameBuf[k][IN_W-1:0];
        xi = frameBuf[k][2*IN_W-1:IN_W];
        m  = (n * k) % 8;
        sr += longint'(xr) * twCos[m] - longint'(xi) * twSin[m];
        si += longint'(xr) * twSin[m] + longint'(xi) * twCos[m];
      end
      vr = scaleSat(sr);
      vi = scaleSat(si);
      expQ.push_back({vi[15:0], vr[15:0]});
    end
    for (int k = 0; k < 8; k++) inQ.push_back(frameBuf[k]);
  endtask

  // gapMode: 0 continuous, 1 toggling, 2 random, 3 toggling for first frame then continuous
  task automatic applyStimulus(input int nBins, input int gapMode);
    int sent = 0;
    int budget = 0;
    logic tog = 1'b1;
    logic offer;
    while (sent < nBins && budget < 3000) begin
      @(negedge clk);
      budget++;
      case (gapMode)
        0: offer = 1'b1;
        1: offer = tog;
        2: offer = 1'($urandom_range(0, 1));
        default: offer = (sent < 8) ? tog : 1'b1;
      endcase
      tog = ~tog;
      bus.in_valid = offer;
      bus.in_data  = inQ[0];
      if (offer && bus.in_ready) begin
        if (sent % 8 == 0) firstEdges.push_back(cycleCnt + 1);
        if (sent % 8 == 7) lastEdges.push_back(cycleCnt + 1);
        void'(inQ.pop_front());
        sent++;
      end
    end
    if (sent < nBins) checkOutput("in_timeout", sent, nBins);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // readyMode: 0 always ready, 1 random, 2 hold off sample 3 for 5 cycles
  task automatic collectOutputs(input int nFrames, input int readyMode);
    int beat = 0;
    int budget = 0;
    int stall = 5;
    int f;
    bit seenFirst = 1'b0;
    logic rdy;
    while (beat < nFrames * 8 && budget < 4000) begin
      @(negedge clk);
      budget++;
      rdy = (readyMode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (readyMode == 2 && beat % 8 == 3 && stall > 0 && bus.out_valid) rdy = 1'b0;
      bus.out_ready = rdy;
      if (bus.out_valid) begin
        f = beat / 8;
        if (!seenFirst) begin
          checkOutput("latency", cycleCnt - lastEdges[f], 65);
          seenFirst = 1'b1;
        end
        if (!rdy && readyMode == 2) begin
          checkOutput("stall_data", bus.out_data, expQ[beat]);
          checkOutput("stall_in_ready", bus.in_ready, 0);
          stall--;
        end
        if (rdy) begin
          checkOutput("data", bus.out_data, expQ[beat]);
          checkOutput("last", bus.out_last, (beat % 8 == 7));
          if (beat % 8 == 7) begin
            lastOutEdges.push_back(cycleCnt + 1);
            seenFirst = 1'b0;
          end
          beat++;
        end
      end
    end
    if (beat < nFrames * 8) checkOutput("out_timeout", beat, nFrames * 8);
    if (readyMode == 2) checkOutput("stall_cycles", stall, 0);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    for (int m = 0; m < 8; m++) begin
      twCos[m] = int'($cos(2.0 * 3.14159265358979 * m / 8.0) * 16384.0);
      twSin[m] = int'($sin(2.0 * 3.14159265358979 * m / 8.0) * 16384.0);
    end
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_data", bus.out_data, 0);
    checkOutput("rst_out_last", bus.out_last, 0);
    rst = 1'b0;

    $display("[TB] DC impulse");
    clearQueues();
    setImpulse(0, 8192);
    queueFrame();
    checkOutput("model_dc", expQ[0], 32'h0000_0400);
    fork
      applyStimulus(8, 0);
      collectOutputs(1, 0);
    join

    $display("[TB] single tone with backpressure on sample 3");
    clearQueues();
    setImpulse(1, 8192);
    queueFrame();
    checkOutput("model_tone_y3", expQ[3], 32'h02D4_FD2C);
    fork
      applyStimulus(8, 0);
      collectOutputs(1, 2);
    join

    $display("[TB] saturation");
    clearQueues();
    for (int k = 0; k < 8; k++) frameBuf[k] = {{IN_W{1'b0}}, IN_W'(262143)};
    queueFrame();
    fork
      applyStimulus(8, 0);
      collectOutputs(1, 0);
    join

    $display("[TB] reset during CALC");
    clearQueues();
    setImpulse(0, 8192);
    queueFrame();
    applyStimulus(8, 0);
    while (cycleCnt < lastEdges[0] + 20) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_in_ready", bus.in_ready, 1);
    checkOutput("midrst_out_valid", bus.out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    clearQueues();
    setImpulse(0, 8192);
    queueFrame();
    fork
      applyStimulus(8, 0);
      collectOutputs(1, 0);
    join

    $display("[TB] gapped frame followed by back-to-back tone");
    clearQueues();
    setImpulse(0, 8192);
    queueFrame();
    setImpulse(1, 8192);
    queueFrame();
    fork
      applyStimulus(16, 3);
      collectOutputs(2, 0);
    join
    checkOutput("b2b_accept_edge", firstEdges[1], lastOutEdges[0] + 1);

    $display("[TB] random frames");
    clearQueues();
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 8; k++) begin
        logic [IN_W-1:0] r, i;
        if (f % 2 == 0) begin
          r = IN_W'(int'($urandom_range(0, 16383)) - 8192);
          i = IN_W'(int'($urandom_range(0, 16383)) - 8192);
        end else begin
          r = IN_W'($urandom);
          i = IN_W'($urandom);
        end
        frameBuf[k] = {i, r};
      end
      queueFrame();
    end
    fork
      applyStimulus(48, 2);
      collectOutputs(6, 1);
    join

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end
endmodule
